// File: rtl/reg_scan_reader_pkg.sv
// Shared types and defaults for the register-bank scan reader.
// Optional checksum beat: define REG_SCAN_CHECKSUM_EN.
package reg_scan_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        CSUM,
        DONE
    } state_t;

    localparam int NUM_REGS_DEF = 32;
    localparam int WIDTH_DEF    = 64;
    localparam int CHUNK_DEF    = 16;

    function automatic int chunks_of(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter width that stays legal when the range collapses to 1.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_scan_shifter.sv
// Snapshot buffer: loads one register, then shifts it out a chunk at a time.
// Independent of REG_SCAN_CHECKSUM_EN.
module reg_scan_shifter
    import reg_scan_reader_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [CHUNK-1:0] low
);

    logic [WIDTH-1:0] data;

    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (load) begin
            data <= din;
        end else if (shift) begin
            data <= data >> CHUNK;
        end
    end

    assign low = data[CHUNK-1:0];

endmodule

// File: rtl/reg_scan_reader.sv
// Streams every register of the bank out as CHUNK-wide valid/ready beats.
// Define REG_SCAN_CHECKSUM_EN to append an XOR checksum beat after the scan.
module reg_scan_reader
    import reg_scan_reader_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int CHUNK    = CHUNK_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_REGS*WIDTH-1:0] regs_in,
    output logic [CHUNK-1:0]          dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      dout_last,
    output logic                      busy,
    output logic                      done
);

    localparam int CHUNKS = chunks_of(WIDTH, CHUNK);
    localparam int IW     = cnt_bits(NUM_REGS);
    localparam int CW     = cnt_bits(CHUNKS);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REGS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CHUNKS - 1);

    state_t           state;
    state_t           state_next;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    chunk_cnt;
    logic [CHUNK-1:0] low;
    logic [WIDTH-1:0] selected;
    logic             load;
    logic             shift;
    logic             last_chunk;
    logic             last_reg;

    assign last_chunk = (chunk_cnt == CNT_LAST);
    assign last_reg   = (idx == IDX_LAST);
    assign load       = (state == LOAD);
    assign shift      = (state == SEND) && dout_ready;
    assign selected   = regs_in[idx*WIDTH +: WIDTH];

    reg_scan_shifter #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) u_shifter (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .shift(shift),
        .din  (selected),
        .low  (low)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // chunk_cnt holds at its top value on the last beat so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            chunk_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) idx <= '0;
                LOAD: chunk_cnt <= '0;
                SEND: begin
                    if (dout_ready && !last_chunk) begin
                        chunk_cnt <= chunk_cnt + 1'b1;
                    end
                    if (dout_ready && last_chunk && !last_reg) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef REG_SCAN_CHECKSUM_EN
    logic [CHUNK-1:0] csum;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= '0;
        end else if (state == IDLE && start) begin
            csum <= '0;
        end else if (shift) begin
            csum <= csum ^ low;
        end
    end
`endif

    always_comb begin
        state_next = state;
        dout       = '0;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = LOAD;
            end
            LOAD: state_next = SEND;
            SEND: begin
                dout_valid = 1'b1;
                dout       = low;
`ifdef REG_SCAN_CHECKSUM_EN
                if (dout_ready && last_chunk) begin
                    state_next = last_reg ? CSUM : LOAD;
                end
`else
                dout_last = last_reg && last_chunk;
                if (dout_ready && last_chunk) begin
                    state_next = last_reg ? DONE : LOAD;
                end
`endif
            end
            CSUM: begin
`ifdef REG_SCAN_CHECKSUM_EN
                dout_valid = 1'b1;
                dout       = csum;
                dout_last  = 1'b1;
                if (dout_ready) state_next = DONE;
`else
                state_next = IDLE;
`endif
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_scan_reader.sv
// Randomized self-checking bench for reg_scan_reader against a beat-list model.
// Also covers the REG_SCAN_CHECKSUM_EN build when that macro is defined.
module tb_reg_scan_reader;

    localparam int NR = 32;
    localparam int W  = 64;
    localparam int C  = 16;
    localparam int CH = W / C;
`ifdef REG_SCAN_CHECKSUM_EN
    localparam int CSUM_BEATS = 1;
`else
    localparam int CSUM_BEATS = 0;
`endif
    localparam int TOTAL = NR * CH + CSUM_BEATS;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            dout_ready;
    logic [NR*W-1:0] regs_in;
    logic [C-1:0]    dout;
    logic            dout_valid;
    logic            dout_last;
    logic            busy;
    logic            done;

    logic [W-1:0] regs_m [NR];
    logic [C-1:0] exp_beats [$];
    logic [C-1:0] got_beats [$];
    logic         got_last [$];
    int first_valid, last_beat_cyc, done_cyc, done_cnt, hold_err, busy_err;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        regs_in = '0;
        for (int i = 0; i < NR; i++) regs_in[i*W +: W] = regs_m[i];
    end

    reg_scan_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .regs_in   (regs_in),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_last (dout_last),
        .busy      (busy),
        .done      (done)
    );

    function automatic void set_pattern();
        for (int i = 0; i < NR; i++) regs_m[i] = 64'h0001_0002_0003_0004 + 64'(i);
    endfunction

    // Model: every register low chunk first, then the XOR of all beats.
    function automatic void build_expected();
        logic [C-1:0] x = '0;
        exp_beats.delete();
        for (int i = 0; i < NR; i++) begin
            for (int c = 0; c < CH; c++) begin
                exp_beats.push_back(regs_m[i][c*C +: C]);
                x = x ^ regs_m[i][c*C +: C];
            end
        end
        if (CSUM_BEATS == 1) exp_beats.push_back(x);
    endfunction

    function automatic int beat_error();
        if (got_beats.size() != exp_beats.size()) return -2;
        for (int k = 0; k < got_beats.size(); k++) begin
            if (got_beats[k] !== exp_beats[k]) return k;
        end
        return -1;
    endfunction

    function automatic int last_error();
        for (int k = 0; k < got_last.size(); k++) begin
            if (got_last[k] !== (k == got_last.size() - 1)) return k;
        end
        return -1;
    endfunction

    // Modes: 0 ready=1, 1 ready 1,0,0,1, 2 random ready+start, 3 snapshot stall.
    task automatic run_scan(input int mode, input int budget);
        bit           stalled = 0;
        logic [C-1:0] pd = '0;
        logic         pl = 1'b0;
        int           stall = 0;
        got_beats.delete();
        got_last.delete();
        first_valid = -1;
        last_beat_cyc = -1;
        done_cyc = -1;
        done_cnt = 0;
        hold_err = 0;
        busy_err = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            case (mode)
                0: dout_ready = 1'b1;
                1: dout_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2: begin
                    dout_ready = 1'($urandom % 2);
                    start      = 1'($urandom % 2);
                end
                default: begin
                    if (got_beats.size() == 1 && stall < 3) begin
                        dout_ready = 1'b0;
                        stall++;
                        regs_m[0] = '1;
                    end else begin
                        dout_ready = 1'b1;
                    end
                end
            endcase
            @(negedge clk);
            if (dout_valid && first_valid < 0) first_valid = cyc;
            if (stalled && (!dout_valid || dout !== pd || dout_last !== pl)) hold_err++;
            if (!busy) busy_err++;
            if (dout_valid && dout_ready) begin
                got_beats.push_back(dout);
                got_last.push_back(dout_last);
                last_beat_cyc = cyc;
            end
            stalled = dout_valid && !dout_ready;
            pd = dout;
            pl = dout_last;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        reset = 1'b1;
        start = 1'b0;
        dout_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) begin
                @(posedge clk);
                #1 reset = 1'b0;
            end
            @(negedge clk);
            checks++;
            if ({dout, dout_valid, dout_last, busy, done} !== '0) begin
                errors++;
                bad++;
                $display("FAIL reset_idle cyc %0d: dout=%h v=%b l=%b busy=%b done=%b, need all 0",
                         k, dout, dout_valid, dout_last, busy, done);
            end
        end
    endtask

    task automatic test_full_scan();
        int e;
        set_pattern();
        build_expected();
        run_scan(0, 400);
        checks++;
        if (first_valid !== 2) begin
            errors++;
            $display("FAIL full_first_valid: got cycle %0d need 2", first_valid);
        end
        checks++;
        if (got_beats.size() != TOTAL) begin
            errors++;
            $display("FAIL full_count: got %0d beats need %0d", got_beats.size(), TOTAL);
        end
        e = beat_error();
        checks++;
        if (e != -1) begin
            errors++;
            $display("FAIL full_beats: first bad index %0d", e);
        end
        checks++;
        if ({got_beats[0], got_beats[1], got_beats[2], got_beats[3]} !== 64'h0004_0003_0002_0001) begin
            errors++;
            $display("FAIL full_reg0: got %h %h %h %h need 0004 0003 0002 0001",
                     got_beats[0], got_beats[1], got_beats[2], got_beats[3]);
        end
        e = last_error();
        checks++;
        if (e != -1 || got_last.size() == 0) begin
            errors++;
            $display("FAIL full_last: wrong dout_last at beat %0d", e);
        end
        checks++;
        if (last_beat_cyc != NR * (CH + 1) + CSUM_BEATS) begin
            errors++;
            $display("FAIL full_timing: last beat at %0d need %0d",
                     last_beat_cyc, NR * (CH + 1) + CSUM_BEATS);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_beat_cyc + 1) begin
            errors++;
            $display("FAIL full_done: count %0d at %0d need 1 at %0d",
                     done_cnt, done_cyc, last_beat_cyc + 1);
        end
        checks++;
        if (busy_err != 0) begin
            errors++;
            $display("FAIL full_busy: busy low %0d times need 0", busy_err);
        end
    endtask

    task automatic test_backpressure();
        int e;
        set_pattern();
        build_expected();
        run_scan(1, 1000);
        e = beat_error();
        checks++;
        if (e != -1) begin
            errors++;
            $display("FAIL bp_beats: first bad index %0d (got %0d beats need %0d)",
                     e, got_beats.size(), TOTAL);
        end
        checks++;
        if (hold_err != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable stalls need 0", hold_err);
        end
        e = last_error();
        checks++;
        if (e != -1) begin
            errors++;
            $display("FAIL bp_last: wrong dout_last at beat %0d", e);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_beat_cyc + 1) begin
            errors++;
            $display("FAIL bp_done: count %0d at %0d need 1 at %0d",
                     done_cnt, done_cyc, last_beat_cyc + 1);
        end
    endtask

    task automatic test_snapshot();
        int e;
        set_pattern();
        build_expected();
        run_scan(3, 1000);
        checks++;
        if (got_beats.size() < 4 || got_beats[2] !== 16'h0002 || got_beats[3] !== 16'h0001) begin
            errors++;
            $display("FAIL snap_reg0: got %0d beats, beats 2,3 = %h %h need 0002 0001",
                     got_beats.size(), got_beats[2], got_beats[3]);
        end
        e = beat_error();
        checks++;
        if (e != -1) begin
            errors++;
            $display("FAIL snap_beats: first bad index %0d", e);
        end
        checks++;
        if (hold_err != 0) begin
            errors++;
            $display("FAIL snap_hold: %0d unstable stalls need 0", hold_err);
        end
        set_pattern();
    endtask

    task automatic test_abort();
        int  n = 0;
        bit  hit = 0;
        int  dn = 0;
        int  e;
        set_pattern();
        dout_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (dout_valid && dout_ready) n++;
            if (n == 5 * CH + 1) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_reach: got %0d beats need %0d", n, 5 * CH + 1);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dout, dout_valid, dout_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: dout=%h v=%b l=%b busy=%b done=%b need all 0",
                     dout, dout_valid, dout_last, busy, done);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL abort_quiet: done/busy seen %0d cycles need 0", dn);
        end
        build_expected();
        run_scan(0, 400);
        e = beat_error();
        checks++;
        if (e != -1 || got_beats[0] !== 16'h0004) begin
            errors++;
            $display("FAIL abort_rescan: first bad index %0d first beat %h need 0004",
                     e, got_beats[0]);
        end
    endtask

    task automatic test_random();
        int e;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NR; i++) regs_m[i] = {$urandom, $urandom};
            build_expected();
            run_scan(2, 3000);
            e = beat_error();
            checks++;
            if (e != -1) begin
                errors++;
                $display("FAIL rand_beats run %0d: first bad index %0d (got %0d need %0d)",
                         r, e, got_beats.size(), TOTAL);
            end
            e = last_error();
            checks++;
            if (e != -1 || hold_err != 0) begin
                errors++;
                $display("FAIL rand_last_hold run %0d: last err %0d holds %0d need -1 0",
                         r, e, hold_err);
            end
            checks++;
            if (done_cnt != 1 || done_cyc != last_beat_cyc + 1) begin
                errors++;
                $display("FAIL rand_done run %0d: count %0d at %0d need 1 at %0d",
                         r, done_cnt, done_cyc, last_beat_cyc + 1);
            end
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_start_in_done run %0d: busy %b need 0", r, busy);
            end
        end
    endtask

`ifdef REG_SCAN_CHECKSUM_EN
    task automatic test_checksum();
        for (int i = 0; i < NR; i++) regs_m[i] = 64'h1234_1234_1234_1234;
        run_scan(0, 400);
        checks++;
        if (got_beats.size() != TOTAL || got_beats[TOTAL-1] !== 16'h0000
            || got_last[TOTAL-1] !== 1'b1) begin
            errors++;
            $display("FAIL csum_beat: %0d beats, final %h last %b need %0d 0000 1",
                     got_beats.size(), got_beats[TOTAL-1], got_last[TOTAL-1], TOTAL);
        end
        checks++;
        if (got_beats[0] !== 16'h1234 || got_last[TOTAL-2] !== 1'b0) begin
            errors++;
            $display("FAIL csum_send: first %h last-send flag %b need 1234 0",
                     got_beats[0], got_last[TOTAL-2]);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        start = 1'b0;
        dout_ready = 1'b0;
        set_pattern();
        test_reset();
        test_full_scan();
        test_backpressure();
        test_snapshot();
        test_abort();
        test_random();
`ifdef REG_SCAN_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/reg_scan_reader.md
# reg_scan_reader

Read-side companion to the datapath register bank. It snapshots one register at a time from the bank's flattened outputs and streams the contents out as fixed-width chunks over a valid/ready handshake. Used for debug dumps and end-of-test state checks, it walks every register from index 0 upward on a single start pulse. It never writes the bank; enables and resets of the bank stay with the write side.

## Interface
Parameters:
- NUM_REGS, 32, number of registers scanned
- WIDTH, 64, bits per register
- CHUNK, 16, bits per output beat; WIDTH % CHUNK == 0 required

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a scan; sampled only in IDLE
- regs_in  in  NUM_REGS*WIDTH  register contents; register i occupies bits [i*WIDTH +: WIDTH]
- dout  out  CHUNK  current beat
- dout_valid  out  1  beat present
- dout_ready  in  1  sink accepts beat
- dout_last  out  1  final beat of the scan
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan completion

## Operation
- CHUNKS = WIDTH/CHUNK (4 at defaults). A handshake occurs on a cycle with dout_valid && dout_ready.
- State machine: IDLE, LOAD, SEND, CSUM (only with the macro defined), DONE.
- IDLE: busy=0, dout_valid=0. start=1 -> LOAD, idx<=0, csum<=0.
- LOAD: shift_buf <= regs_in[idx]; chunk_cnt<=0; -> SEND. busy=1, dout_valid=0.
- SEND: dout_valid=1, dout=shift_buf[CHUNK-1:0] (least-significant chunk first).
  - On handshake: shift_buf shifts right by CHUNK; chunk_cnt++.
  - If chunk_cnt==CHUNKS-1 and idx<NUM_REGS-1: idx++ -> LOAD.
  - If chunk_cnt==CHUNKS-1 and idx==NUM_REGS-1: -> CSUM, or -> DONE when the macro is undefined.
- DONE: done=1 for exactly one cycle; busy=1 -> IDLE.
- dout and dout_last hold stable while dout_valid=1 and dout_ready=0.
- dout_valid never drops without a handshake.
- start is ignored outside IDLE.
- regs_in is sampled only in LOAD. Later changes to a register being streamed do not affect its beats.
- idx and chunk_cnt are sized $clog2 of their ranges. Neither wraps during a scan.

## Timing
- Reset values: dout=0, dout_valid=0, dout_last=0, busy=0, done=0. The state is IDLE and all counters are 0.
- Reset asserted mid-scan aborts on the next edge to IDLE. No done pulse is produced.
- start sampled at edge N: LOAD at N+1, first dout_valid=1 at N+2.
- Each register takes 1 LOAD cycle plus CHUNKS beats. Back-to-back registers therefore show a one-cycle dout_valid gap.
- With dout_ready held at 1, a full scan is NUM_REGS*(CHUNKS+1) cycles from LOAD to the last beat (160 at defaults), plus 1 CSUM cycle if enabled, then 1 DONE cycle.
- If start=1 during the DONE cycle, it is not sampled. The next scan needs start while in IDLE.

## Configuration
- REG_SCAN_CHECKSUM_EN defined:
  - csum is the running XOR of every CHUNK-wide beat handshaken in SEND.
  - CSUM presents dout=csum with dout_valid=1 and dout_last=1. Handshake -> DONE.
  - dout_last is 0 on all SEND beats.
- REG_SCAN_CHECKSUM_EN undefined:
  - No CSUM state and no csum register.
  - dout_last=1 on the final SEND beat (idx==NUM_REGS-1, chunk_cnt==CHUNKS-1).

## Structure
- Shared package holds:
  - the state enum: IDLE, LOAD, SEND, CSUM, DONE
  - the default NUM_REGS, WIDTH and CHUNK localparams
  - the CHUNKS derivation
- One sub-module, reg_scan_shifter: a WIDTH-bit load/shift-by-CHUNK buffer with load and shift enables, exposing the low CHUNK bits. The FSM, counters and checksum stay in the top level.

## Test plan
- Reset and idle: reset=1 for 2 cycles, then start=0 for 10 cycles -> all outputs 0 throughout and busy=0.
- Full scan with ready=1: register i = 64'h0001_0002_0003_0004 + i, start pulse.
  - First valid beat at N+2; beats for register 0 are 0004, 0003, 0002, 0001.
  - 128 beats total, dout_last on the final beat, done one cycle after the last beat (one cycle after CSUM when enabled).
- Backpressure: toggle dout_ready 1,0,0,1 repeatedly during the same scan.
  - dout stays stable while not ready; the beat sequence is identical to the previous case.
  - No beat is duplicated or dropped.
- Snapshot: change register 0 to 64'hFFFF_FFFF_FFFF_FFFF while its second beat is stalled -> remaining beats are still 0002 and 0001.
- Abort: assert reset during register 5 -> next-edge outputs are 0 and no done pulse. A fresh start rescans from register 0.
- Checksum build (REG_SCAN_CHECKSUM_EN): all registers = 64'h1234_1234_1234_1234.
  - 128 beats of 1234 give a csum of 16'h0000.
  - The extra final beat shows dout=0000 with dout_last=1.
